// File: rtl/din_capture_pkg.sv
// Shared types for the operand input capture stage.
package din_capture_pkg;

    localparam int BYTE_W = 8;

    // Capture FSM encodings
    typedef enum logic [1:0] {
        DIN_IDLE = 2'd0,
        DIN_LO   = 2'd1,
        DIN_HI   = 2'd2
    } din_state_e;

    // Replicate the sign bit of a displacement byte into a full byte
    function automatic logic [BYTE_W-1:0] sext_byte(input logic [BYTE_W-1:0] b);
        return {BYTE_W{b[BYTE_W-1]}};
    endfunction

endpackage

// File: rtl/din_capture_if.sv
// Request/data-bus and capture-result signals of the operand capture stage.
interface din_capture_if;
    import din_capture_pkg::*;

    logic              rd_start;
    logic              rd_len;
    logic              rd_sext;
    logic              bus_ack;
    logic [BYTE_W-1:0] data_in;
    logic              flush;
    logic [BYTE_W-1:0] din0_reg;
    logic [BYTE_W-1:0] din1_reg;
    logic              din_vld;
    logic              din_busy;
    logic              rd_err;

    // Sequencer / bus side
    modport master (
        output rd_start, rd_len, rd_sext, bus_ack, data_in, flush,
        input  din0_reg, din1_reg, din_vld, din_busy, rd_err
    );

    // Capture stage side
    modport slave (
        input  rd_start, rd_len, rd_sext, bus_ack, data_in, flush,
        output din0_reg, din1_reg, din_vld, din_busy, rd_err
    );

endinterface

// File: rtl/din_capture.sv
// Operand input capture: sequences one- or two-byte reads from the data bus
// into din0/din1, with optional sign extension of one-byte displacements.
module din_capture
    import din_capture_pkg::*;
(
    input  logic          clkc,
    input  logic          resetb,
    din_capture_if.slave  bus
);

    din_state_e        state_q, state_d;
    logic [BYTE_W-1:0] din0_q, din0_d;
    logic [BYTE_W-1:0] din1_q, din1_d;
    logic              len_q, len_d;
    logic              sext_q, sext_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    // Next-state and capture decode; flush overrides everything else
    always_comb begin
        state_d = state_q;
        din0_d  = din0_q;
        din1_d  = din1_q;
        len_d   = len_q;
        sext_d  = sext_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;

        if (bus.flush) begin
            state_d = DIN_IDLE;
        end else begin
            case (state_q)
                DIN_IDLE: begin
                    // An ack arriving with (or without) a start is dropped
                    if (bus.rd_start) begin
                        state_d = DIN_LO;
                        len_d   = bus.rd_len;
                        sext_d  = bus.rd_sext;
                    end
                end
                DIN_LO: begin
                    err_d = bus.rd_start;
                    if (bus.bus_ack) begin
                        din0_d = bus.data_in;
                        if (len_q) begin
                            state_d = DIN_HI;
                        end else begin
                            state_d = DIN_IDLE;
                            vld_d   = 1'b1;
                            // Without sext din1 is left alone so {A, din0} I/O
                            // addressing is not disturbed
                            if (sext_q) din1_d = sext_byte(bus.data_in);
                        end
                    end
                end
                DIN_HI: begin
                    err_d = bus.rd_start;
                    if (bus.bus_ack) begin
                        din1_d  = bus.data_in;
                        state_d = DIN_IDLE;
                        vld_d   = 1'b1;
                    end
                end
                default: state_d = DIN_IDLE;
            endcase
        end

        busy_d = (state_d != DIN_IDLE);
    end

    // State and output registers
    always_ff @(posedge clkc or negedge resetb) begin
        if (!resetb) begin
            state_q <= DIN_IDLE;
            din0_q  <= '0;
            din1_q  <= '0;
            len_q   <= 1'b0;
            sext_q  <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din0_q  <= din0_d;
            din1_q  <= din1_d;
            len_q   <= len_d;
            sext_q  <= sext_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.din0_reg = din0_q;
    assign bus.din1_reg = din1_q;
    assign bus.din_vld  = vld_q;
    assign bus.din_busy = busy_q;
    assign bus.rd_err   = err_q;

endmodule

// File: tb/tb_din_capture.sv
// Directed bench for the operand capture stage.
module tb_din_capture;

    logic clkc;
    logic resetb;
    int   n_chk;
    int   n_pass;
    int   busy_cnt;
    int   vld_cnt;

    din_capture_if bus ();

    din_capture dut (
        .clkc   (clkc),
        .resetb (resetb),
        .bus    (bus)
    );

    initial clkc = 1'b0;
    always #5 clkc = ~clkc;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge; inputs applied before are sampled on it, outputs read 1 after
    task automatic tick();
        @(posedge clkc);
        #1;
        busy_cnt += int'(bus.din_busy);
        vld_cnt  += int'(bus.din_vld);
    endtask

    task automatic idle_in();
        bus.rd_start = 1'b0;
        bus.rd_len   = 1'b0;
        bus.rd_sext  = 1'b0;
        bus.bus_ack  = 1'b0;
        bus.data_in  = 8'h00;
        bus.flush    = 1'b0;
    endtask

    task automatic start(input logic len, input logic sext);
        idle_in();
        bus.rd_start = 1'b1;
        bus.rd_len   = len;
        bus.rd_sext  = sext;
        tick();
        idle_in();
    endtask

    task automatic ack(input logic [7:0] d);
        idle_in();
        bus.bus_ack = 1'b1;
        bus.data_in = d;
        tick();
        idle_in();
    endtask

    initial begin
        n_chk = 0; n_pass = 0; busy_cnt = 0; vld_cnt = 0;
        idle_in();
        resetb = 1'b0;
        #12;
        chk("rst_din0", {8'h0, bus.din0_reg}, 16'h0000);
        chk("rst_din1", {8'h0, bus.din1_reg}, 16'h0000);
        chk("rst_flags", {13'h0, bus.din_vld, bus.din_busy, bus.rd_err}, 16'h0000);
        @(posedge clkc); #1;
        resetb = 1'b1;
        tick();

        // Two-byte capture with two wait states before the high byte
        busy_cnt = 0; vld_cnt = 0;
        start(1'b1, 1'b0);
        chk("2b_busy_after_start", {15'h0, bus.din_busy}, 16'h1);
        ack(8'h34);
        chk("2b_din0", {8'h0, bus.din0_reg}, 16'h0034);
        chk("2b_no_vld_lo", {15'h0, bus.din_vld}, 16'h0);
        tick(); tick();
        ack(8'h12);
        chk("2b_din1", {8'h0, bus.din1_reg}, 16'h0012);
        chk("2b_vld_busy", {14'h0, bus.din_vld, bus.din_busy}, 16'h2);
        tick();
        chk("2b_vld_drop", {15'h0, bus.din_vld}, 16'h0);
        chk("2b_busy_cycles", 16'(busy_cnt), 16'd4);
        chk("2b_vld_pulses", 16'(vld_cnt), 16'd1);

        // Sign extension of negative and positive displacements
        start(1'b0, 1'b1);
        ack(8'hF0);
        chk("sx_neg", {bus.din1_reg, bus.din0_reg}, 16'hFFF0);
        chk("sx_neg_vld", {15'h0, bus.din_vld}, 16'h1);
        start(1'b0, 1'b1);
        ack(8'h7F);
        chk("sx_pos", {bus.din1_reg, bus.din0_reg}, 16'h007F);

        // Preload din1 = AB, then an unextended single byte keeps it
        start(1'b1, 1'b0);
        ack(8'h01);
        ack(8'hAB);
        start(1'b0, 1'b0);
        ack(8'h55);
        chk("nosx_keep", {bus.din1_reg, bus.din0_reg}, 16'hAB55);
        chk("nosx_vld", {15'h0, bus.din_vld}, 16'h1);

        // sext ignored for two-byte reads
        start(1'b1, 1'b1);
        ack(8'h80);
        ack(8'h02);
        chk("sx_len1", {bus.din1_reg, bus.din0_reg}, 16'h0280);
        start(1'b1, 1'b0);
        ack(8'h01);
        ack(8'hAB);

        // Flush in HI beats a simultaneous ack
        start(1'b1, 1'b0);
        ack(8'h11);
        bus.flush = 1'b1; bus.bus_ack = 1'b1; bus.data_in = 8'hEE;
        tick();
        idle_in();
        chk("fl_hi_regs", {bus.din1_reg, bus.din0_reg}, 16'hAB11);
        chk("fl_hi_flags", {14'h0, bus.din_vld, bus.din_busy}, 16'h0);
        ack(8'h77);
        chk("fl_hi_idle", {bus.din0_reg, 7'h0, bus.din_busy}, 16'h1100);

        // Flush beats start in IDLE
        bus.flush = 1'b1; bus.rd_start = 1'b1; bus.rd_len = 1'b0;
        tick();
        idle_in();
        chk("fl_start_busy", {15'h0, bus.din_busy}, 16'h0);
        ack(8'h66);
        chk("fl_start_noreg", {8'h0, bus.din0_reg}, 16'h0011);

        // Start while in LO: error pulse, original two-byte length kept
        start(1'b1, 1'b0);
        start(1'b0, 1'b1);
        chk("err_pulse", {15'h0, bus.rd_err}, 16'h1);
        tick();
        chk("err_drop", {14'h0, bus.rd_err, bus.din_busy}, 16'h1);
        ack(8'h22);
        chk("err_len_kept", {14'h0, bus.din_vld, bus.din_busy}, 16'h1);
        ack(8'h33);
        chk("err_done", {bus.din1_reg, bus.din0_reg}, 16'h3322);
        chk("err_done_vld", {15'h0, bus.din_vld}, 16'h1);

        // Ack in IDLE changes nothing
        ack(8'h99);
        chk("idle_ack", {bus.din1_reg, bus.din0_reg}, 16'h3322);
        chk("idle_ack_flags", {13'h0, bus.din_vld, bus.din_busy, bus.rd_err}, 16'h0);

        // Back-to-back: start on the din_vld cycle
        start(1'b0, 1'b0);
        ack(8'h44);
        chk("b2b_first", {7'h0, bus.din_vld, bus.din0_reg}, 16'h0144);
        start(1'b0, 1'b0);
        chk("b2b_accept", {13'h0, bus.din_vld, bus.din_busy, bus.rd_err}, 16'h2);
        ack(8'h45);
        chk("b2b_second", {7'h0, bus.din_vld, bus.din0_reg}, 16'h0145);

        // Asynchronous reset in HI
        start(1'b1, 1'b0);
        ack(8'h5A);
        #2;
        resetb = 1'b0;
        #1;
        chk("arst_regs", {bus.din1_reg, bus.din0_reg}, 16'h0000);
        chk("arst_flags", {13'h0, bus.din_vld, bus.din_busy, bus.rd_err}, 16'h0);
        @(posedge clkc); #1;
        resetb = 1'b1;
        ack(8'hC3);
        chk("arst_idle", {bus.din1_reg, bus.din0_reg}, 16'h0000);
        chk("arst_idle_flags", {14'h0, bus.din_vld, bus.din_busy}, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
